// File: rtl/third_mode_countdown.sv
// rtl/third_mode_countdown.sv - timed third-mode session with whole-second countdown and exit request
module third_mode_countdown #(
  parameter int                    CLK_FREQ_HZ = 100_000_000,
  parameter int                    RUN_SECONDS = 60,
  parameter int                    SEC_W       = 7,
  parameter int                    MODE_WIDTH  = 3,
  parameter logic [MODE_WIDTH-1:0] OFF_MODE    = 3'd0,
  parameter logic [MODE_WIDTH-1:0] STAND_MODE  = 3'd1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MODE_WIDTH-1:0] current_mode,
  input  logic                  third_mode_toggle,
  input  logic                  menu_signal,
  output logic                  third_active,
  output logic [SEC_W-1:0]      seconds_left,
  output logic                  exit_to_stand,
  output logic                  exit_cause
);

  localparam int               PRE_W    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ_HZ - 1);
  localparam logic [SEC_W-1:0] SEC_INIT = SEC_W'(RUN_SECONDS);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EXIT = 2'd2
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] prescaler;
  logic             tick;

  // One-second tick: the cycle on which the prescaler wraps back to zero
  assign tick = (prescaler == PRE_LAST);

  // Session FSM; OFF mode overrides everything, menu beats a same-cycle final tick
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      prescaler     <= '0;
      third_active  <= 1'b0;
      seconds_left  <= '0;
      exit_to_stand <= 1'b0;
      exit_cause    <= 1'b0;
    end else if (current_mode == OFF_MODE) begin
      state         <= IDLE;
      prescaler     <= '0;
      third_active  <= 1'b0;
      seconds_left  <= '0;
      exit_to_stand <= 1'b0;
      exit_cause    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          exit_to_stand <= 1'b0;
          if (third_mode_toggle && (current_mode == STAND_MODE)) begin
            state        <= RUN;
            prescaler    <= '0;
            third_active <= 1'b1;
            seconds_left <= SEC_INIT;
          end
        end
        RUN: begin
          if (menu_signal) begin
            state         <= EXIT;
            prescaler     <= '0;
            third_active  <= 1'b0;
            seconds_left  <= '0;
            exit_to_stand <= 1'b1;
            exit_cause    <= 1'b1;
          end else if (tick) begin
            prescaler <= '0;
            if (seconds_left == SEC_ONE) begin
              state         <= EXIT;
              third_active  <= 1'b0;
              seconds_left  <= '0;
              exit_to_stand <= 1'b1;
              exit_cause    <= 1'b0;
            end else begin
              seconds_left <= seconds_left - SEC_ONE;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        EXIT: begin
          state         <= IDLE;
          exit_to_stand <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          prescaler     <= '0;
          third_active  <= 1'b0;
          seconds_left  <= '0;
          exit_to_stand <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_third_mode_countdown.sv
// tb/tb_third_mode_countdown.sv - self-checking bench for third_mode_countdown
module tb_third_mode_countdown;

  localparam int         CLK_HZ  = 4;
  localparam int         RUN_S   = 3;
  localparam int         SEC_W   = 7;
  localparam logic [2:0] M_OFF   = 3'd0;
  localparam logic [2:0] M_STAND = 3'd1;
  localparam logic [2:0] M_FIRST = 3'd2;
  localparam logic [2:0] M_OTHER = 3'd3;

  logic             clk;
  logic             rstn;
  logic [2:0]       current_mode;
  logic             third_mode_toggle;
  logic             menu_signal;
  logic             third_active;
  logic [SEC_W-1:0] seconds_left;
  logic             exit_to_stand;
  logic             exit_cause;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 0;

  // reference state
  int m_act, m_left, m_exit, m_cause, m_el;

  third_mode_countdown #(
    .CLK_FREQ_HZ(CLK_HZ),
    .RUN_SECONDS(RUN_S),
    .SEC_W      (SEC_W),
    .MODE_WIDTH (3),
    .OFF_MODE   (M_OFF),
    .STAND_MODE (M_STAND)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .current_mode     (current_mode),
    .third_mode_toggle(third_mode_toggle),
    .menu_signal      (menu_signal),
    .third_active     (third_active),
    .seconds_left     (seconds_left),
    .exit_to_stand    (exit_to_stand),
    .exit_cause       (exit_cause)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic exp_out(input string name, input int a, input int l, input int e, input int c);
    check({name, ".active"}, int'(third_active), a);
    check({name, ".left"},   int'(seconds_left), l);
    check({name, ".exit"},   int'(exit_to_stand), e);
    check({name, ".cause"},  int'(exit_cause), c);
  endtask

  task automatic run_cycle(input logic tg, input logic mn, input logic [2:0] md);
    #1;
    third_mode_toggle = tg;
    menu_signal       = mn;
    current_mode      = md;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, M_STAND);
  endtask

  // Reference: session measured as elapsed cycles since start; seconds from division
  always @(posedge clk) begin
    if (!rstn || current_mode == M_OFF) begin
      m_act = 0; m_left = 0; m_exit = 0; m_cause = 0; m_el = 0;
    end else if (m_act != 0) begin
      m_el++;
      if (menu_signal || m_el == RUN_S * CLK_HZ) begin
        m_act = 0; m_left = 0; m_exit = 1;
        m_cause = menu_signal ? 1 : 0;
      end else begin
        m_left = RUN_S - m_el / CLK_HZ;
      end
    end else if (m_exit != 0) begin
      m_exit = 0;
    end else if (third_mode_toggle && current_mode == M_STAND) begin
      m_act = 1; m_el = 0; m_left = RUN_S;
    end
  end

  // Per-cycle comparison against the reference, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model.active", int'(third_active), m_act);
      check("model.left",   int'(seconds_left), m_left);
      check("model.exit",   int'(exit_to_stand), m_exit);
      check("model.cause",  int'(exit_cause), m_cause);
    end
  end

  initial begin
    rstn = 0; third_mode_toggle = 0; menu_signal = 0; current_mode = M_STAND;
    m_act = 0; m_left = 0; m_exit = 0; m_cause = 0; m_el = 0;
    repeat (3) @(negedge clk);
    exp_out("reset", 0, 0, 0, 0);
    #1 rstn = 1;
    @(negedge clk);
    cmp_en = 1;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      exp_out("idle", 0, 0, 0, 0);
      run_cycle(1'b0, 1'b0, M_STAND);
    end

    // 2: full timeout session
    run_cycle(1'b1, 1'b0, M_STAND);
    for (int k = 1; k <= 14; k++) begin
      exp_out($sformatf("timeout.t%0d", k), (k <= 12) ? 1 : 0,
              (k <= 4) ? 3 : (k <= 8) ? 2 : (k <= 12) ? 1 : 0, (k == 13) ? 1 : 0, 0);
      idle(1);
    end

    // 3: menu abort at t+6
    run_cycle(1'b1, 1'b0, M_STAND);
    idle(5);
    run_cycle(1'b0, 1'b1, M_STAND);
    exp_out("menu.t7", 0, 0, 1, 1);
    for (int k = 8; k <= 16; k++) begin
      idle(1);
      exp_out($sformatf("menu.t%0d", k), 0, 0, 0, 1);
    end

    // 4: OFF at t+6, then fresh start
    run_cycle(1'b1, 1'b0, M_STAND);
    idle(5);
    run_cycle(1'b0, 1'b0, M_OFF);
    exp_out("off.t7", 0, 0, 0, 0);
    run_cycle(1'b0, 1'b0, M_OFF);
    exp_out("off.t8", 0, 0, 0, 0);
    run_cycle(1'b1, 1'b0, M_STAND);
    exp_out("restart", 1, 3, 0, 0);
    idle(14);

    // reset mid-session: immediate clear, no pulse on release
    run_cycle(1'b1, 1'b0, M_STAND);
    idle(2);
    #1 rstn = 0;
    @(negedge clk);
    exp_out("rst.mid", 0, 0, 0, 0);
    @(negedge clk);
    #1 rstn = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      exp_out("rst.after", 0, 0, 0, 0);
      idle(1);
    end

    // 5: second toggle ignored; toggle in FIRST ignored
    run_cycle(1'b1, 1'b0, M_STAND);
    idle(2);
    run_cycle(1'b1, 1'b0, M_STAND);
    exp_out("retog.t4", 1, 3, 0, 0);
    idle(8);
    exp_out("retog.t12", 1, 1, 0, 0);
    idle(1);
    exp_out("retog.t13", 0, 0, 1, 0);
    idle(1);
    run_cycle(1'b1, 1'b0, M_FIRST);
    exp_out("first.tog", 0, 0, 0, 0);
    idle(3);
    exp_out("first.later", 0, 0, 0, 0);

    // 6: menu on the final tick; menu with OFF
    run_cycle(1'b1, 1'b0, M_STAND);
    idle(11);
    exp_out("lastmenu.t12", 1, 1, 0, 0);
    run_cycle(1'b0, 1'b1, M_STAND);
    exp_out("lastmenu.t13", 0, 0, 1, 1);
    idle(2);
    run_cycle(1'b1, 1'b0, M_STAND);
    idle(2);
    run_cycle(1'b0, 1'b1, M_OFF);
    exp_out("menuoff", 0, 0, 0, 0);
    idle(3);
    exp_out("menuoff.later", 0, 0, 0, 0);

    // randomized traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [2:0] md;
      r  = $urandom_range(0, 99);
      md = (r < 3) ? M_OFF : (r < 10) ? M_FIRST : (r < 12) ? M_OTHER : M_STAND;
      if ($urandom_range(0, 799) == 0) begin
        #1 rstn = 0;
        @(negedge clk);
        @(negedge clk);
        #1 rstn = 1;
        @(negedge clk);
      end
      run_cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 59) == 0), md);
    end

    cmp_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
